// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates ALU/LSU writebacks onto the single
// write port and keeps a pending-write scoreboard for decode hazard checks.
module rf_wb_scheduler #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_REGS   = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              alu_valid_in,
    input  logic [ADDR_W-1:0] alu_rd_addr_in,
    input  logic [DATA_W-1:0] alu_rd_data_in,
    output logic              alu_ready_out,
    input  logic              lsu_valid_in,
    input  logic [ADDR_W-1:0] lsu_rd_addr_in,
    input  logic [DATA_W-1:0] lsu_rd_data_in,
    output logic              lsu_ready_out,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic [DATA_W-1:0] rd_data_out,
    input  logic              alloc_en_in,
    input  logic [ADDR_W-1:0] alloc_addr_in,
    output logic              alloc_stall_out,
    input  logic [ADDR_W-1:0] rs1_addr_in,
    input  logic [ADDR_W-1:0] rs2_addr_in,
    output logic              rs1_busy_out,
    output logic              rs2_busy_out
);

    logic                last_lsu_q, last_lsu_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic                lsu_wins, alu_gnt, lsu_gnt, xfer;
    logic [ADDR_W-1:0]   gnt_addr;
    logic [DATA_W-1:0]   gnt_data;
    logic [NUM_REGS-1:0] clr_vec, set_vec;
    logic                alloc_busy, alloc_hit_clr, stall;

    // Out-of-range addresses (when NUM_REGS < 2**ADDR_W) read as never busy.
    function automatic logic busy_at(input logic [NUM_REGS-1:0] vec,
                                     input logic [ADDR_W-1:0]   a);
        return (int'(a) < NUM_REGS) ? vec[a] : 1'b0;
    endfunction

    always_comb begin
        lsu_wins = (FIXED_PRIO != 0) || !last_lsu_q;
        alu_gnt  = !rst_in && alu_valid_in && !(lsu_valid_in && lsu_wins);
        lsu_gnt  = !rst_in && lsu_valid_in && !(alu_valid_in && !lsu_wins);
        xfer     = alu_gnt || lsu_gnt;
        gnt_addr = lsu_gnt ? lsu_rd_addr_in : alu_rd_addr_in;
        gnt_data = lsu_gnt ? lsu_rd_data_in : alu_rd_data_in;
    end

    // A writeback retiring the same register this cycle releases a WAW stall;
    // the new reservation is then applied after the clear so it survives.
    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            clr_vec[i] = xfer && (gnt_addr == ADDR_W'(i));
        end
        alloc_busy    = busy_at(busy_q, alloc_addr_in);
        alloc_hit_clr = busy_at(clr_vec, alloc_addr_in);
        stall         = !rst_in && alloc_en_in && alloc_busy && !alloc_hit_clr;
        for (int i = 1; i < NUM_REGS; i++) begin
            set_vec[i] = !rst_in && alloc_en_in && !stall && (alloc_addr_in == ADDR_W'(i));
        end
        busy_d    = (busy_q & ~clr_vec) | set_vec;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        last_lsu_d = xfer ? lsu_gnt : last_lsu_q;
        wr_en_d    = xfer && (gnt_addr != '0);
        rd_addr_d  = xfer ? gnt_addr : rd_addr_q;
        rd_data_d  = xfer ? gnt_data : rd_data_q;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            last_lsu_q <= 1'b1;
            busy_q     <= '0;
            wr_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            last_lsu_q <= last_lsu_d;
            busy_q     <= busy_d;
            wr_en_q    <= wr_en_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign alu_ready_out   = alu_gnt;
    assign lsu_ready_out   = lsu_gnt;
    assign wr_en_out       = wr_en_q;
    assign rd_addr_out     = rd_addr_q;
    assign rd_data_out     = rd_data_q;
    assign alloc_stall_out = stall;
    assign rs1_busy_out    = !rst_in && busy_at(busy_q, rs1_addr_in);
    assign rs2_busy_out    = !rst_in && busy_at(busy_q, rs2_addr_in);

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Bench for rf_wb_scheduler: round-robin and fixed-priority instances share stimulus
// and are both checked every cycle against a behavioural model.
module tb_rf_wb_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, av, lv, ae;
    logic [4:0]  aa, la, aea, rs1, rs2;
    logic [31:0] ad, ld;

    logic [1:0]       ar_o, lr_o, wen_o, st_o, b1_o, b2_o;
    logic [1:0][4:0]  raddr_o;
    logic [1:0][31:0] rdata_o;

    rf_wb_scheduler #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .FIXED_PRIO(0)) u_rr (
        .clk_in(clk), .rst_in(rst),
        .alu_valid_in(av), .alu_rd_addr_in(aa), .alu_rd_data_in(ad), .alu_ready_out(ar_o[0]),
        .lsu_valid_in(lv), .lsu_rd_addr_in(la), .lsu_rd_data_in(ld), .lsu_ready_out(lr_o[0]),
        .wr_en_out(wen_o[0]), .rd_addr_out(raddr_o[0]), .rd_data_out(rdata_o[0]),
        .alloc_en_in(ae), .alloc_addr_in(aea), .alloc_stall_out(st_o[0]),
        .rs1_addr_in(rs1), .rs2_addr_in(rs2), .rs1_busy_out(b1_o[0]), .rs2_busy_out(b2_o[0])
    );

    rf_wb_scheduler #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32), .FIXED_PRIO(1)) u_fp (
        .clk_in(clk), .rst_in(rst),
        .alu_valid_in(av), .alu_rd_addr_in(aa), .alu_rd_data_in(ad), .alu_ready_out(ar_o[1]),
        .lsu_valid_in(lv), .lsu_rd_addr_in(la), .lsu_rd_data_in(ld), .lsu_ready_out(lr_o[1]),
        .wr_en_out(wen_o[1]), .rd_addr_out(raddr_o[1]), .rd_data_out(rdata_o[1]),
        .alloc_en_in(ae), .alloc_addr_in(aea), .alloc_stall_out(st_o[1]),
        .rs1_addr_in(rs1), .rs2_addr_in(rs2), .rs1_busy_out(b1_o[1]), .rs2_busy_out(b2_o[1])
    );

    int total = 0;
    int bad   = 0;

    // Model state: index 0 = round-robin, 1 = fixed priority.
    bit        m_last_lsu[2];
    bit [31:0] m_busy[2];
    bit        m_wr[2];
    bit [4:0]  m_addr[2];
    bit [31:0] m_data[2];
    bit        e_ar[2], e_lr[2], e_st[2], e_b1[2], e_b2[2];

    task automatic chk(input string nm, input int p, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[inst%0d] @%0t actual=%h required=%h", nm, p, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_last_lsu[p] = 1'b1;
            m_busy[p]     = '0;
            m_wr[p]       = 1'b0;
            m_addr[p]     = '0;
            m_data[p]     = '0;
        end
    endtask

    task automatic compute_exp();
        for (int p = 0; p < 2; p++) begin
            bit lsu_first;
            int clr;
            if (rst) begin
                e_ar[p] = 0; e_lr[p] = 0; e_st[p] = 0; e_b1[p] = 0; e_b2[p] = 0;
            end else begin
                lsu_first = (p == 1) ? 1'b1 : !m_last_lsu[p];
                e_ar[p] = av && !(lv && lsu_first);
                e_lr[p] = lv && !(av && !lsu_first);
                clr = -1;
                if (e_ar[p] && aa != 0) clr = int'(aa);
                if (e_lr[p] && la != 0) clr = int'(la);
                e_st[p] = ae && aea != 0 && m_busy[p][aea] && clr != int'(aea);
                e_b1[p] = rs1 != 0 && m_busy[p][rs1];
                e_b2[p] = rs2 != 0 && m_busy[p][rs2];
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        compute_exp();
        for (int p = 0; p < 2; p++) begin
            chk("alu_ready", p, 32'(ar_o[p]), 32'(e_ar[p]));
            chk("lsu_ready", p, 32'(lr_o[p]), 32'(e_lr[p]));
            chk("alloc_stall", p, 32'(st_o[p]), 32'(e_st[p]));
            chk("rs1_busy", p, 32'(b1_o[p]), 32'(e_b1[p]));
            chk("rs2_busy", p, 32'(b2_o[p]), 32'(e_b2[p]));
            chk("wr_en", p, 32'(wen_o[p]), 32'(m_wr[p]));
            chk("rd_addr", p, 32'(raddr_o[p]), 32'(m_addr[p]));
            chk("rd_data", p, rdata_o[p], m_data[p]);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int p = 0; p < 2; p++) begin
                bit [4:0] g;
                g = e_lr[p] ? la : aa;
                if (e_ar[p] || e_lr[p]) begin
                    m_last_lsu[p] = e_lr[p];
                    m_wr[p]   = (g != 0);
                    m_addr[p] = g;
                    m_data[p] = e_lr[p] ? ld : ad;
                    if (g != 0) m_busy[p][g] = 1'b0;
                end else begin
                    m_wr[p] = 1'b0;
                end
                if (ae && aea != 0 && !e_st[p]) m_busy[p][aea] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic cycle();
        sample();
        adv();
    endtask

    task automatic idle();
        av = 0; lv = 0; ae = 0;
        aa = 0; la = 0; ad = 0; ld = 0; aea = 0; rs1 = 0; rs2 = 0;
    endtask

    bit a_pend, l_pend;

    initial begin
        rst = 1;
        idle();
        model_reset();
        #1;
        cycle();
        cycle();
        rst = 0;
        sample();
        chk("lit_reset_wr_en", 0, 32'(wen_o[0]), 32'd0);
        chk("lit_reset_rd_data", 0, rdata_o[0], 32'd0);
        adv();

        // ALU-only writeback to a reserved register
        ae = 1; aea = 5;
        cycle();
        ae = 0; av = 1; aa = 5; ad = 32'hDEADBEEF; rs1 = 5;
        sample();
        chk("lit_alu_ready", 0, 32'(ar_o[0]), 32'd1);
        chk("lit_x5_busy", 0, 32'(b1_o[0]), 32'd1);
        adv();
        av = 0;
        sample();
        chk("lit_wr_en", 0, 32'(wen_o[0]), 32'd1);
        chk("lit_rd_addr", 0, 32'(raddr_o[0]), 32'd5);
        chk("lit_rd_data", 0, rdata_o[0], 32'hDEADBEEF);
        chk("lit_x5_clear", 0, 32'(b1_o[0]), 32'd0);
        adv();

        // Conflict from a fresh pointer
        rst = 1; idle();
        cycle();
        rst = 0;
        av = 1; aa = 3; ad = 32'h11; lv = 1; la = 4; ld = 32'h22;
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("lit_rr_alu", 0, 32'(ar_o[0]), 32'((k % 2) == 0));
            chk("lit_rr_lsu", 0, 32'(lr_o[0]), 32'((k % 2) == 1));
            chk("lit_fp_lsu", 1, 32'(lr_o[1]), 32'd1);
            if (k > 0) chk("lit_rr_pulse", 0, 32'(wen_o[0]), 32'd1);
            adv();
        end
        idle();
        sample();
        chk("lit_rr_pulse", 0, 32'(wen_o[0]), 32'd1);
        chk("lit_rr_last_data", 0, rdata_o[0], 32'h22);
        adv();

        // x0 filter
        lv = 1; la = 0; ld = 32'hFFFFFFFF;
        sample();
        chk("lit_x0_ready", 0, 32'(lr_o[0]), 32'd1);
        chk("lit_x0_rs1", 0, 32'(b1_o[0]), 32'd0);
        adv();
        lv = 0;
        sample();
        chk("lit_x0_wr_en", 0, 32'(wen_o[0]), 32'd0);
        adv();

        // WAW
        ae = 1; aea = 7;
        sample();
        chk("lit_waw_first", 0, 32'(st_o[0]), 32'd0);
        adv();
        sample();
        chk("lit_waw_stall", 0, 32'(st_o[0]), 32'd1);
        adv();
        av = 1; aa = 7; ad = 32'h77;
        sample();
        chk("lit_waw_release", 0, 32'(st_o[0]), 32'd0);
        adv();
        idle(); rs1 = 7;
        sample();
        chk("lit_waw_still_busy", 0, 32'(b1_o[0]), 32'd1);
        adv();
        av = 1; aa = 7;
        cycle();
        idle();

        // RAW
        ae = 1; aea = 9;
        cycle();
        ae = 0; rs2 = 9;
        sample();
        chk("lit_raw_busy", 0, 32'(b2_o[0]), 32'd1);
        adv();
        lv = 1; la = 9; ld = 32'h99;
        sample();
        chk("lit_raw_busy_xfer", 0, 32'(b2_o[0]), 32'd1);
        adv();
        lv = 0;
        sample();
        chk("lit_raw_clear", 0, 32'(b2_o[0]), 32'd0);
        adv();

        // Reset mid-op
        ae = 1; aea = 2;
        cycle();
        ae = 0; av = 1; aa = 2; ad = 32'h22222222; rs1 = 2;
        sample();
        chk("lit_rst_grant", 0, 32'(ar_o[0]), 32'd1);
        adv();
        rst = 1; lv = 1; la = 6;
        sample();
        chk("lit_rst_alu_rdy", 0, 32'(ar_o[0]), 32'd0);
        chk("lit_rst_lsu_rdy", 0, 32'(lr_o[0]), 32'd0);
        adv();
        rst = 0; av = 0; lv = 0;
        sample();
        chk("lit_rst_wr_en", 0, 32'(wen_o[0]), 32'd0);
        chk("lit_rst_busy", 0, 32'(b1_o[0]), 32'd0);
        adv();

        // Randomized traffic; requests are held until the round-robin instance accepts.
        idle();
        a_pend = 0; l_pend = 0;
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!a_pend && $urandom_range(0, 2) != 0) begin
                a_pend = 1; aa = 5'($urandom_range(0, 15)); ad = $urandom;
            end
            if (!l_pend && $urandom_range(0, 2) != 0) begin
                l_pend = 1; la = 5'($urandom_range(0, 15)); ld = $urandom;
            end
            av  = a_pend;
            lv  = l_pend;
            ae  = ($urandom_range(0, 1) == 1);
            aea = 5'($urandom_range(0, 15));
            rs1 = 5'($urandom_range(0, 15));
            rs2 = 5'($urandom_range(0, 15));
            sample();
            if (e_ar[0]) a_pend = 0;
            if (e_lr[0]) l_pend = 0;
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
